// File: rtl/noc_io_stager.sv
// noc_io_stager: stages BRAM reads into a packed NoC input vector (GIN) and drains GON opsum vectors back to BRAM.
// Optional feature macro STAGER_RELU_EN: clamp negative opsum lanes to zero on write-back.
module noc_io_stager #(
  parameter int LANES            = 4,
  parameter int LANE_W           = 8,
  parameter int PSUM_W           = 32,
  parameter int DATA_BITWIDTH    = 32,
  parameter int ADDRESS_BITWIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [$clog2(LANES)-1:0]      ld_lane,
  input  logic                          ld_pad,
  input  logic                          ld_last,
  input  logic [DATA_BITWIDTH-1:0]      bram_rdata,
  output logic                          gin_enable,
  input  logic                          gin_ready,
  output logic [LANES*LANE_W-1:0]       gin_value,
  input  logic                          gon_enable,
  output logic                          gon_ready,
  input  logic [LANES*PSUM_W-1:0]       gon_value,
  input  logic [ADDRESS_BITWIDTH-1:0]   wr_base,
  output logic [ADDRESS_BITWIDTH-1:0]   oarg_address,
  output logic [DATA_BITWIDTH-1:0]      oarg_wdata,
  output logic                          oarg_e,
  output logic [3:0]                    oarg_we,
  output logic                          drain_done
);

  localparam int LANE_IDX_W = $clog2(LANES);
  localparam logic [LANE_IDX_W-1:0]       LAST_LANE = LANE_IDX_W'(LANES - 1);
  localparam logic [ADDRESS_BITWIDTH-1:0] ADDR_STEP = ADDRESS_BITWIDTH'(4);

  typedef enum logic [1:0] {IN_FILL, IN_CAPT, IN_SEND} in_state_e;
  typedef enum logic       {OUT_IDLE, OUT_DRAIN}       out_state_e;

  // ---------------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------------
  in_state_e              in_state_reg;
  logic [LANE_IDX_W-1:0]  lane_idx_reg;
  logic                   pad_reg;
  logic                   last_reg;
  logic                   ld_ready_reg;
  logic                   gin_enable_reg;
  logic [LANE_W-1:0]      lane_reg [LANES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_state_reg   <= IN_FILL;
      lane_idx_reg   <= '0;
      pad_reg        <= 1'b0;
      last_reg       <= 1'b0;
      ld_ready_reg   <= 1'b1;
      gin_enable_reg <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lane_reg[i] <= '0;
      end
    end else begin
      case (in_state_reg)
        IN_FILL: begin
          if (ld_valid) begin
            lane_idx_reg <= ld_lane;
            pad_reg      <= ld_pad;
            last_reg     <= ld_last;
            ld_ready_reg <= 1'b0;
            in_state_reg <= IN_CAPT;
          end
        end
        IN_CAPT: begin
          // BRAM data for the request issued in IN_FILL is valid in this cycle.
          lane_reg[lane_idx_reg] <= pad_reg ? '0 : bram_rdata[LANE_W-1:0];
          if (last_reg) begin
            gin_enable_reg <= 1'b1;
            in_state_reg   <= IN_SEND;
          end else begin
            ld_ready_reg <= 1'b1;
            in_state_reg <= IN_FILL;
          end
        end
        IN_SEND: begin
          if (gin_ready) begin
            gin_enable_reg <= 1'b0;
            ld_ready_reg   <= 1'b1;
            in_state_reg   <= IN_FILL;
          end
        end
        default: begin
          gin_enable_reg <= 1'b0;
          ld_ready_reg   <= 1'b1;
          in_state_reg   <= IN_FILL;
        end
      endcase
    end
  end

  assign ld_ready   = ld_ready_reg;
  assign gin_enable = gin_enable_reg;

  // Lane 0 sits in the most significant slot of the GIN vector.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_gin_pack
    assign gin_value[(LANES-1-gi)*LANE_W +: LANE_W] = lane_reg[gi];
  end

  if (LANE_W < DATA_BITWIDTH) begin : g_rdata_hi
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^bram_rdata[DATA_BITWIDTH-1:LANE_W];
  end

  // ---------------------------------------------------------------------------
  // Output side
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_BITWIDTH-1:0] relu(input logic [PSUM_W-1:0] v);
`ifdef STAGER_RELU_EN
    return v[PSUM_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  logic [PSUM_W-1:0] gon_lane [LANES];

  // Lane 0 sits in the least significant slot of the GON vector.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_gon_unpack
    assign gon_lane[gi] = gon_value[gi*PSUM_W +: PSUM_W];
  end

  out_state_e                  out_state_reg;
  logic [LANE_IDX_W-1:0]       k_reg;
  logic [LANE_IDX_W-1:0]       k_next;
  logic [PSUM_W-1:0]           psum_reg [LANES];
  logic                        gon_ready_reg;
  logic                        drain_done_reg;
  logic                        oarg_e_reg;
  logic [3:0]                  oarg_we_reg;
  logic [ADDRESS_BITWIDTH-1:0] oarg_address_reg;
  logic [DATA_BITWIDTH-1:0]    oarg_wdata_reg;

  assign k_next = k_reg + LANE_IDX_W'(1);

  // Write-port outputs are registered one step ahead: the accept edge already
  // loads lane 0's write, so every OUT_DRAIN cycle presents a valid write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_state_reg    <= OUT_IDLE;
      k_reg            <= '0;
      gon_ready_reg    <= 1'b1;
      drain_done_reg   <= 1'b0;
      oarg_e_reg       <= 1'b0;
      oarg_we_reg      <= 4'h0;
      oarg_address_reg <= '0;
      oarg_wdata_reg   <= '0;
      for (int i = 0; i < LANES; i++) begin
        psum_reg[i] <= '0;
      end
    end else begin
      drain_done_reg <= 1'b0;
      case (out_state_reg)
        OUT_IDLE: begin
          if (gon_enable) begin
            for (int i = 0; i < LANES; i++) begin
              psum_reg[i] <= gon_lane[i];
            end
            k_reg            <= '0;
            gon_ready_reg    <= 1'b0;
            oarg_e_reg       <= 1'b1;
            oarg_we_reg      <= 4'hF;
            oarg_address_reg <= wr_base;
            oarg_wdata_reg   <= relu(gon_lane[0]);
            out_state_reg    <= OUT_DRAIN;
          end
        end
        OUT_DRAIN: begin
          if (k_reg == LAST_LANE) begin
            gon_ready_reg    <= 1'b1;
            drain_done_reg   <= 1'b1;
            oarg_e_reg       <= 1'b0;
            oarg_we_reg      <= 4'h0;
            oarg_address_reg <= '0;
            oarg_wdata_reg   <= '0;
            out_state_reg    <= OUT_IDLE;
          end else begin
            // Plain add wraps modulo 2^ADDRESS_BITWIDTH.
            k_reg            <= k_next;
            oarg_address_reg <= oarg_address_reg + ADDR_STEP;
            oarg_wdata_reg   <= relu(psum_reg[k_next]);
          end
        end
        default: begin
          gon_ready_reg    <= 1'b1;
          oarg_e_reg       <= 1'b0;
          oarg_we_reg      <= 4'h0;
          oarg_address_reg <= '0;
          oarg_wdata_reg   <= '0;
          out_state_reg    <= OUT_IDLE;
        end
      endcase
    end
  end

  assign gon_ready    = gon_ready_reg;
  assign drain_done   = drain_done_reg;
  assign oarg_e       = oarg_e_reg;
  assign oarg_we      = oarg_we_reg;
  assign oarg_address = oarg_address_reg;
  assign oarg_wdata   = oarg_wdata_reg;

endmodule

// File: tb/tb_noc_io_stager.sv
// tb_noc_io_stager: table vectors, hand corner sequences and concurrent random traffic
// against an array/arithmetic reference model; honours STAGER_RELU_EN for expected write data.
module tb_noc_io_stager;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int PSUM_W = 32;
  localparam int DW     = 32;
  localparam int AW     = 32;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    ld_valid = 1'b0;
  logic                    ld_ready;
  logic [1:0]              ld_lane = '0;
  logic                    ld_pad = 1'b0;
  logic                    ld_last = 1'b0;
  logic [DW-1:0]           bram_rdata = '0;
  logic                    gin_enable;
  logic                    gin_ready = 1'b0;
  logic [LANES*LANE_W-1:0] gin_value;
  logic                    gon_enable = 1'b0;
  logic                    gon_ready;
  logic [LANES*PSUM_W-1:0] gon_value = '0;
  logic [AW-1:0]           wr_base = '0;
  logic [AW-1:0]           oarg_address;
  logic [DW-1:0]           oarg_wdata;
  logic                    oarg_e;
  logic [3:0]              oarg_we;
  logic                    drain_done;

  noc_io_stager #(
    .LANES(LANES), .LANE_W(LANE_W), .PSUM_W(PSUM_W),
    .DATA_BITWIDTH(DW), .ADDRESS_BITWIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_lane(ld_lane), .ld_pad(ld_pad),
    .ld_last(ld_last), .bram_rdata(bram_rdata),
    .gin_enable(gin_enable), .gin_ready(gin_ready), .gin_value(gin_value),
    .gon_enable(gon_enable), .gon_ready(gon_ready), .gon_value(gon_value),
    .wr_base(wr_base), .oarg_address(oarg_address), .oarg_wdata(oarg_wdata),
    .oarg_e(oarg_e), .oarg_we(oarg_we), .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the value each lane should hold.
  logic [LANE_W-1:0] model_lane [LANES];

  typedef struct {
    logic [1:0]  lane;
    logic        pad;
    logic [31:0] rdata;
    logic        last;
    int          hold;
    logic [31:0] exp_gin;
  } ld_vec_t;

  ld_vec_t tbl [10];

  function automatic logic [31:0] model_gin();
    logic [31:0] acc = '0;
    for (int i = 0; i < LANES; i++) acc = (acc << LANE_W) | 32'(model_lane[i]);
    return acc;
  endfunction

  function automatic logic [31:0] relu_model(input logic [31:0] v);
`ifdef STAGER_RELU_EN
    if ($signed(v) < 0) return 32'd0;
`endif
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_write_idle(input string tag);
    check({tag, "_oarg_e"}, 64'(oarg_e), 64'd0);
    check({tag, "_oarg_we"}, 64'(oarg_we), 64'd0);
    check({tag, "_oarg_addr"}, 64'(oarg_address), 64'd0);
    check({tag, "_oarg_wdata"}, 64'(oarg_wdata), 64'd0);
  endtask

  // Checks LANES write cycles then the drain_done cycle. With chain set,
  // gon_enable is held high with the next vector throughout.
  task automatic expect_drain(input logic [31:0] base, input logic [127:0] gv, input bit chain,
                              input logic [31:0] nbase, input logic [127:0] ngv);
    for (int k = 0; k < LANES; k++) begin
      logic [31:0] ea;
      ea = base + 32'(4 * k);
      check("drain_e", 64'(oarg_e), 64'd1);
      check("drain_we", 64'(oarg_we), 64'hF);
      check("drain_addr", 64'(oarg_address), 64'(ea));
      check("drain_wdata", 64'(oarg_wdata), 64'(relu_model(gv[k*32 +: 32])));
      check("drain_gon_ready", 64'(gon_ready), 64'd0);
      check("drain_done_early", 64'(drain_done), 64'd0);
      if (chain) begin
        gon_enable = 1'b1; gon_value = ngv; wr_base = nbase;
      end else begin
        wr_base = $urandom;
        gon_value = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
    end
    check("drain_done_pulse", 64'(drain_done), 64'd1);
    check("drain_gon_ready_back", 64'(gon_ready), 64'd1);
    check_write_idle("after_drain");
    $display("[tb] drain base=0x%08h complete at %0t", base, $time);
  endtask

  task automatic present(input logic [31:0] base, input logic [127:0] gv);
    gon_enable = 1'b1; gon_value = gv; wr_base = base;
    check("present_gon_ready", 64'(gon_ready), 64'd1);
    step();
    gon_enable = 1'b0;
  endtask

  task automatic run_random_loads(input int n);
    for (int v = 0; v < n; v++) begin
      int nloads;
      int hold;
      logic [31:0] exp_v;
      nloads = $urandom_range(1, 5);
      for (int j = 0; j < nloads; j++) begin
        logic [1:0] ln;
        logic pd;
        logic [31:0] dat;
        if ($urandom_range(0, 2) == 0) begin
          ld_valid = 1'b0;
          step();
          check("rnd_idle_ready", 64'(ld_ready), 64'd1);
        end
        ln = 2'($urandom_range(0, 3));
        pd = ($urandom_range(0, 3) == 0);
        dat = $urandom;
        check("rnd_ld_ready", 64'(ld_ready), 64'd1);
        check("rnd_gin_idle", 64'(gin_enable), 64'd0);
        ld_valid = 1'b1; ld_lane = ln; ld_pad = pd; ld_last = (j == nloads - 1);
        bram_rdata = $urandom;
        step();
        // Fields and valid are junk here; only bram_rdata matters.
        ld_valid = 1'($urandom); ld_lane = 2'($urandom); ld_pad = 1'($urandom);
        ld_last = 1'($urandom); gin_ready = 1'($urandom); bram_rdata = dat;
        check("rnd_capt_ready", 64'(ld_ready), 64'd0);
        step();
        ld_valid = 1'b0; gin_ready = 1'b0;
        model_lane[ln] = pd ? '0 : dat[LANE_W-1:0];
        check("rnd_gin_value", 64'(gin_value), 64'(model_gin()));
      end
      exp_v = model_gin();
      check("rnd_gin_en", 64'(gin_enable), 64'd1);
      check("rnd_send_ready", 64'(ld_ready), 64'd0);
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        ld_valid = 1'($urandom);
        step();
        check("rnd_hold_en", 64'(gin_enable), 64'd1);
        check("rnd_hold_value", 64'(gin_value), 64'(exp_v));
      end
      gin_ready = 1'b1; ld_valid = 1'b0;
      step();
      gin_ready = 1'b0;
      check("rnd_sent_en", 64'(gin_enable), 64'd0);
      $display("[tb] random vector %0d sent gin=0x%08h", v, exp_v);
    end
  endtask

  task automatic run_random_drains(input int n);
    for (int d = 0; d < n; d++) begin
      logic [31:0] b;
      logic [127:0] g;
      int gap;
      b = (d == 0) ? 32'hFFFF_FFF8 : $urandom;
      g = {$urandom, $urandom, $urandom, $urandom};
      present(b, g);
      expect_drain(b, g, 1'b0, 32'd0, 128'd0);
      gap = $urandom_range(0, 2);
      for (int s = 0; s < gap; s++) begin
        step();
        check("rnd_gap_done", 64'(drain_done), 64'd0);
        check("rnd_gap_e", 64'(oarg_e), 64'd0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] gv_a;
    logic [127:0] gv_b;
    for (int i = 0; i < LANES; i++) model_lane[i] = '0;

    tbl[0] = '{2'd0, 1'b0, 32'hDEAD_BE11, 1'b0, 0, 32'h1100_0000};
    tbl[1] = '{2'd1, 1'b0, 32'h0000_0022, 1'b0, 0, 32'h1122_0000};
    tbl[2] = '{2'd2, 1'b0, 32'h1234_5633, 1'b0, 0, 32'h1122_3300};
    tbl[3] = '{2'd3, 1'b0, 32'h0000_0044, 1'b1, 0, 32'h1122_3344};
    tbl[4] = '{2'd0, 1'b0, 32'h0000_0011, 1'b0, 0, 32'h1122_3344};
    tbl[5] = '{2'd1, 1'b0, 32'h0000_0022, 1'b0, 0, 32'h1122_3344};
    tbl[6] = '{2'd2, 1'b1, 32'h0000_0099, 1'b0, 0, 32'h1122_0044};
    tbl[7] = '{2'd3, 1'b0, 32'h0000_0044, 1'b1, 5, 32'h1122_0044};
    tbl[8] = '{2'd1, 1'b0, 32'hFFFF_FFAB, 1'b1, 1, 32'h11AB_0044};
    tbl[9] = '{2'd3, 1'b1, 32'h0000_0077, 1'b1, 0, 32'h11AB_0000};

    // Reset values while rst is held low.
    #12;
    check("rst_ld_ready", 64'(ld_ready), 64'd1);
    check("rst_gon_ready", 64'(gon_ready), 64'd1);
    check("rst_gin_enable", 64'(gin_enable), 64'd0);
    check("rst_gin_value", 64'(gin_value), 64'd0);
    check("rst_drain_done", 64'(drain_done), 64'd0);
    check_write_idle("rst");
    @(negedge clk);
    rst = 1'b1;
    step();
    check("post_rst_ld_ready", 64'(ld_ready), 64'd1);

    // Table-driven load vectors.
    for (int i = 0; i < 10; i++) begin
      check("tbl_ld_ready", 64'(ld_ready), 64'd1);
      ld_valid = 1'b1; ld_lane = tbl[i].lane; ld_pad = tbl[i].pad; ld_last = tbl[i].last;
      bram_rdata = 32'hFFFF_FFFF;
      step();
      ld_valid = 1'b0; bram_rdata = tbl[i].rdata;
      check("tbl_capt_ready", 64'(ld_ready), 64'd0);
      check("tbl_capt_gin_en", 64'(gin_enable), 64'd0);
      step();
      bram_rdata = '0;
      model_lane[tbl[i].lane] = tbl[i].pad ? '0 : tbl[i].rdata[LANE_W-1:0];
      check("tbl_gin_value", 64'(gin_value), 64'(tbl[i].exp_gin));
      check("tbl_gin_en", 64'(gin_enable), 64'(tbl[i].last));
      if (tbl[i].last) begin
        for (int h = 0; h < tbl[i].hold; h++) begin
          step();
          check("tbl_hold_en", 64'(gin_enable), 64'd1);
          check("tbl_hold_value", 64'(gin_value), 64'(tbl[i].exp_gin));
          check("tbl_hold_ld_ready", 64'(ld_ready), 64'd0);
        end
        gin_ready = 1'b1;
        step();
        gin_ready = 1'b0;
        check("tbl_sent_en", 64'(gin_enable), 64'd0);
        check("tbl_sent_ld_ready", 64'(ld_ready), 64'd1);
      end
      $display("[tb] table load %0d lane=%0d gin=0x%08h", i, tbl[i].lane, gin_value);
    end

    // Opsum lanes {1,2,-3,4} to 0x100, then a back-to-back vector offered during the drain.
    gv_a = {32'd4, 32'hFFFF_FFFD, 32'd2, 32'd1};
    gv_b = {32'h8000_0000, 32'd7, 32'hFFFF_FFFF, 32'h0000_1234};
    present(32'h0000_0100, gv_a);
    expect_drain(32'h0000_0100, gv_a, 1'b1, 32'h0000_0400, gv_b);
    step();
    gon_enable = 1'b0;
    expect_drain(32'h0000_0400, gv_b, 1'b0, 32'd0, 128'd0);
    step();
    check("single_pulse_done", 64'(drain_done), 64'd0);
    check("single_pulse_e", 64'(oarg_e), 64'd0);

    // Address wrap at the top of the address space.
    present(32'hFFFF_FFFC, gv_a);
    check("wrap_first_addr", 64'(oarg_address), 64'hFFFF_FFFC);
    step();
    check("wrap_second_addr", 64'(oarg_address), 64'h0000_0000);
    step(); step(); step();
    check("wrap_done", 64'(drain_done), 64'd1);

    // Reset in the middle of a drain, after two writes.
    present(32'h0000_0200, gv_b);
    check("mid_w0_addr", 64'(oarg_address), 64'h200);
    step();
    check("mid_w1_addr", 64'(oarg_address), 64'h204);
    step();
    check("mid_w2_e", 64'(oarg_e), 64'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_gon_ready", 64'(gon_ready), 64'd1);
    check("mid_rst_gin_value", 64'(gin_value), 64'd0);
    check("mid_rst_done", 64'(drain_done), 64'd0);
    check_write_idle("mid_rst");
    for (int i = 0; i < LANES; i++) model_lane[i] = '0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("post_mid_done", 64'(drain_done), 64'd0);
      check("post_mid_e", 64'(oarg_e), 64'd0);
      check("post_mid_gon_ready", 64'(gon_ready), 64'd1);
    end

    // Independent random traffic on both sides at once.
    fork
      run_random_loads(20);
      run_random_drains(15);
    join

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
